// File: rtl/nn_intent_argmax.sv
// nn_intent_argmax
//   Picks the winning intent from a vector of N_CLASSES signed class scores.
//   The vector and the confidence threshold are snapshotted on the input
//   handshake. The scores are then scanned one class per cycle through a
//   single shared comparator. The result is held until the consumer takes it.
//
// Ports
//   clk_i, reset_i   clock, synchronous active-high reset
//   in_valid_i       score vector valid
//   in_ready_o       block can accept a vector (IDLE only)
//   scores_i         packed scores, class k at [k*DATA_W +: DATA_W]
//   margin_th_i      unsigned confidence threshold, sampled on accept
//   out_valid_o      result valid
//   out_ready_i      consumer accepts result
//   out_class_o      index of the maximum score (lowest index on ties)
//   out_score_o      maximum score (signed)
//   out_margin_o     best minus second best, saturated, never negative
//   out_low_conf_o   out_margin_o < captured threshold (unsigned)
//   busy_o           high in SCAN or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a score vector, in_ready_o high
// SCAN  | comparing one captured class per cycle against best/second
// DONE  | result presented, held until out_ready_i

module nn_intent_argmax #(
  parameter int N_CLASSES = 8,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [N_CLASSES*DATA_W-1:0] scores_i,
  input  logic [DATA_W-1:0]           margin_th_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [IDX_W-1:0]            out_class_o,
  output logic [DATA_W-1:0]           out_score_o,
  output logic [DATA_W-1:0]           out_margin_o,
  output logic                        out_low_conf_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t             state_q;
  logic [DATA_W-1:0]  score_q [N_CLASSES];
  logic [DATA_W-1:0]  th_q;
  logic [DATA_W-1:0]  best_q;
  logic [DATA_W-1:0]  second_q;
  logic [IDX_W-1:0]   bidx_q;
  logic [IDX_W-1:0]   idx_q;

  logic               out_valid_q;
  logic [IDX_W-1:0]   out_class_q;
  logic [DATA_W-1:0]  out_score_q;
  logic [DATA_W-1:0]  out_margin_q;
  logic               out_low_conf_q;
  logic               busy_q;

  logic [DATA_W-1:0]  cur_score;
  logic [DATA_W-1:0]  best_d;
  logic [DATA_W-1:0]  second_d;
  logic [IDX_W-1:0]   bidx_d;
  logic [DATA_W:0]    diff_d;
  logic [DATA_W-1:0]  margin_d;
  logic               low_conf_d;

  // Combinational outcome of comparing the current class; the SCAN step
  // commits it, and the final step also feeds it straight into the outputs.
  always_comb begin
    cur_score = score_q[idx_q];
    best_d    = best_q;
    second_d  = second_q;
    bidx_d    = bidx_q;
    if ($signed(cur_score) > $signed(best_q)) begin
      second_d = best_q;
      best_d   = cur_score;
      bidx_d   = idx_q;
    end else if ($signed(cur_score) > $signed(second_q)) begin
      second_d = cur_score;
    end
  end

  // best >= second always holds, so the DATA_W+1 bit difference lies in
  // [0, 2^DATA_W - 1]; only the upper half needs clamping.
  always_comb begin
    diff_d = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
    if (diff_d[DATA_W]) begin
      margin_d = '0;
    end else if (diff_d[DATA_W-1]) begin
      margin_d = MOST_POS;
    end else begin
      margin_d = diff_d[DATA_W-1:0];
    end
    low_conf_d = (margin_d < th_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      for (int k = 0; k < N_CLASSES; k++) begin
        score_q[k] <= '0;
      end
      th_q           <= '0;
      best_q         <= '0;
      second_q       <= '0;
      bidx_q         <= '0;
      idx_q          <= '0;
      out_valid_q    <= 1'b0;
      out_class_q    <= '0;
      out_score_q    <= '0;
      out_margin_q   <= '0;
      out_low_conf_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            for (int k = 0; k < N_CLASSES; k++) begin
              score_q[k] <= scores_i[k*DATA_W +: DATA_W];
            end
            th_q     <= margin_th_i;
            best_q   <= scores_i[DATA_W-1:0];
            second_q <= MOST_NEG;
            bidx_q   <= '0;
            idx_q    <= IDX_W'(1);
            busy_q   <= 1'b1;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_q   <= best_d;
          second_q <= second_d;
          bidx_q   <= bidx_d;
          idx_q    <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            out_valid_q    <= 1'b1;
            out_class_q    <= bidx_d;
            out_score_q    <= best_d;
            out_margin_q   <= margin_d;
            out_low_conf_q <= low_conf_d;
            state_q        <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the block reports not-ready during reset and ready on
  // the very first cycle after release.
  assign in_ready_o     = (state_q == S_IDLE) && !reset_i;
  assign out_valid_o    = out_valid_q;
  assign out_class_o    = out_class_q;
  assign out_score_o    = out_score_q;
  assign out_margin_o   = out_margin_q;
  assign out_low_conf_o = out_low_conf_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_nn_intent_argmax.sv
module tb_nn_intent_argmax;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [N*DW-1:0] scores_i = '0;
  logic [DW-1:0]   margin_th_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [IW-1:0]   out_class_o;
  logic [DW-1:0]  out_score_o;
  logic [DW-1:0]  out_margin_o;
  logic            out_low_conf_o;
  logic            busy_o;

  int errs   = 0;
  int checks = 0;

  logic signed [DW-1:0] sv [N];
  logic [IW-1:0]        exp_cls;
  logic [DW-1:0]        exp_score;
  logic [DW-1:0]        exp_margin;
  logic                 exp_low;

  nn_intent_argmax #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .scores_i       (scores_i),
    .margin_th_i    (margin_th_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_class_o    (out_class_o),
    .out_score_o    (out_score_o),
    .out_margin_o   (out_margin_o),
    .out_low_conf_o (out_low_conf_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [N*DW-1:0] pack_sv();
    logic [N*DW-1:0] p;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = sv[k];
    return p;
  endfunction

  // Reference: winner = first occurrence of the maximum; runner-up = the
  // largest of all the other entries (so a duplicated maximum gives margin 0).
  task automatic model(input logic [DW-1:0] th);
    int    bi;
    longint sec, m;
    bi = 0;
    for (int k = 1; k < N; k++) if (sv[k] > sv[bi]) bi = k;
    sec = -(64'sd1 <<< (DW-1));
    for (int k = 0; k < N; k++) if (k != bi && longint'(sv[k]) > sec) sec = sv[k];
    m = longint'(sv[bi]) - sec;
    if (m > ((64'sd1 <<< (DW-1)) - 1)) m = (64'sd1 <<< (DW-1)) - 1;
    exp_cls    = IW'(bi);
    exp_score  = sv[bi];
    exp_margin = DW'(m);
    exp_low    = (m < longint'({32'd0, th}));
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".class"},  out_class_o,    exp_cls);
    chk({tag, ".score"},  out_score_o,    exp_score);
    chk({tag, ".margin"}, out_margin_o,   exp_margin);
    chk({tag, ".lowc"},   out_low_conf_o, exp_low);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, ".valid"},  out_valid_o,    1'b0);
    chk({tag, ".class"},  out_class_o,    '0);
    chk({tag, ".score"},  out_score_o,    '0);
    chk({tag, ".margin"}, out_margin_o,   '0);
    chk({tag, ".lowc"},   out_low_conf_o, 1'b0);
    chk({tag, ".busy"},   busy_o,         1'b0);
  endtask

  // Accepts the vector in sv, scrambles the inputs during SCAN, checks the
  // latency and result, optionally holds DONE under backpressure, releases.
  task automatic run_vec(input string tag, input logic [DW-1:0] th,
                         input bit perturb, input int hold);
    int n;
    model(th);
    n = 0;
    while (!in_ready_o && n < 20) begin tick(); n++; end
    chk({tag, ".in_ready"}, in_ready_o, 1'b1);
    scores_i    = pack_sv();
    margin_th_i = th;
    in_valid_i  = 1'b1;
    tick();
    in_valid_i  = 1'b0;
    chk({tag, ".busy_scan"}, busy_o, 1'b1);
    chk({tag, ".rdy_scan"}, in_ready_o, 1'b0);
    if (perturb) begin
      scores_i = '0;
      scores_i[7*DW +: DW] = 32'h7FFF_FFFF;
      margin_th_i = '0;
    end else begin
      for (int k = 0; k < N; k++) scores_i[k*DW +: DW] = $urandom;
      margin_th_i = $urandom;
    end
    n = 0;
    while (!out_valid_o && n < 20) begin tick(); n++; end
    chk({tag, ".latency"}, 64'(n), 64'd7);
    check_result(tag);
    chk({tag, ".rdy_done"}, in_ready_o, 1'b0);
    for (int c = 0; c < hold; c++) begin
      in_valid_i = c[0];
      for (int k = 0; k < N; k++) scores_i[k*DW +: DW] = $urandom;
      margin_th_i = $urandom;
      tick();
      chk({tag, ".hold.valid"}, out_valid_o, 1'b1);
      chk({tag, ".hold.rdy"}, in_ready_o, 1'b0);
      check_result({tag, ".hold"});
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, ".post.valid"}, out_valid_o, 1'b0);
    chk({tag, ".post.rdy"}, in_ready_o, 1'b1);
    chk({tag, ".post.busy"}, busy_o, 1'b0);
    check_result({tag, ".kept"});
  endtask

  initial begin
    reset_i = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", in_ready_o, 1'b0);
    check_idle_zero("rst");
    reset_i = 1'b0;
    #1;
    chk("rst.release_rdy", in_ready_o, 1'b1);

    // Directed: mixed scores, near-tie between 100 and 99
    sv = '{32'sd10, 32'sd20, 32'sd5, -32'sd3, 32'sd100, 32'sd7, 32'sd99, 32'sd0};
    run_vec("t1", 32'd5, 1'b0, 0);
    chk("t1.class4", out_class_o, 3'd4);
    chk("t1.margin1", out_margin_o, 32'd1);

    // All equal: lowest index wins, margin 0
    for (int k = 0; k < N; k++) sv[k] = 32'sd42;
    run_vec("t2a", 32'd1, 1'b0, 0);
    run_vec("t2b", 32'd0, 1'b0, 0);
    chk("t2b.lowc0", out_low_conf_o, 1'b0);

    // Saturated margin
    sv[0] = 32'h7FFF_FFFF;
    for (int k = 1; k < N; k++) sv[k] = 32'h8000_0000;
    run_vec("t3a", 32'h100, 1'b0, 0);
    chk("t3a.sat", out_margin_o, 32'h7FFF_FFFF);

    // All negative
    sv = '{-32'sd5, -32'sd1, -32'sd9, -32'sd9, -32'sd9, -32'sd9, -32'sd9, -32'sd9};
    run_vec("t3b", 32'd0, 1'b0, 0);
    chk("t3b.score", out_score_o, 32'hFFFF_FFFF);
    chk("t3b.margin4", out_margin_o, 32'd4);

    // Backpressure for 20 cycles with IN_VALID pulsing
    sv = '{32'sd10, 32'sd20, 32'sd5, -32'sd3, 32'sd100, 32'sd7, 32'sd99, 32'sd0};
    run_vec("t4", 32'd5, 1'b0, 20);

    // Snapshot: class 7 made largest and threshold zeroed during SCAN
    run_vec("t5", 32'd5, 1'b1, 0);
    chk("t5.class", out_class_o, 3'd4);

    // Reset at scan cycle 3 aborts
    for (int k = 0; k < N; k++) sv[k] = $urandom;
    scores_i   = pack_sv();
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    chk("t6.rst_rdy", in_ready_o, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("t6.rdy_after", in_ready_o, 1'b1);
    check_idle_zero("t6");
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (out_valid_o) seen++;
      end
      chk("t6.no_valid", 64'(seen), 64'd0);
    end
    for (int k = 0; k < N; k++) sv[k] = $signed(32'($urandom_range(0, 200))) - 32'sd100;
    run_vec("t6.next", 32'd3, 1'b0, 0);

    // Randomized vectors, some drawn from a narrow range to force ties
    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] th;
      for (int k = 0; k < N; k++) begin
        if (t % 3 == 0) sv[k] = $signed(32'($urandom_range(0, 6))) - 32'sd3;
        else if (t % 3 == 1) sv[k] = $urandom;
        else sv[k] = (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFF0) + 32'($urandom_range(0, 15));
      end
      th = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8)) : $urandom;
      run_vec("rnd", th, 1'b0, t % 4);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/nn_intent_argmax.md
Name: nn_intent_argmax

Overview:
- Downstream stage of the Avalon-MM neural-net interface. Consumes the 8 class scores (O_1..O_8, signed 32-bit fixed point) and produces the winning intent index, its score, and the best-to-second-best margin.
- Also produces a low-confidence flag against a runtime threshold.
- Snapshots the scores on a valid/ready handshake, then scans them sequentially. This gives a single shared comparator and stable results while the upstream outputs keep changing.

Parameters:
N_CLASSES, 8, number of class scores (must be >= 2)
DATA_W, 32, score width, signed two's complement
IDX_W, 3, class index width (>= clog2(N_CLASSES))

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
IN_VALID  in  1  score vector valid
IN_READY  out  1  block can accept a vector (high only in IDLE)
SCORES  in  N_CLASSES*DATA_W  packed scores; class k at bits [k*DATA_W +: DATA_W]; class 0 = O_1
MARGIN_TH  in  DATA_W  unsigned confidence threshold, sampled on accept
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts result
OUT_CLASS  out  IDX_W  index of maximum score
OUT_SCORE  out  DATA_W  maximum score (signed)
OUT_MARGIN  out  DATA_W  best minus second-best, saturated, non-negative
OUT_LOW_CONF  out  1  OUT_MARGIN < MARGIN_TH (unsigned)
BUSY  out  1  high in SCAN or DONE

Behaviour:
- One clock domain (CLK). RESET is synchronous and active-high.
- On reset:
  - state goes to IDLE.
  - OUT_VALID, OUT_CLASS, OUT_SCORE, OUT_MARGIN, OUT_LOW_CONF and BUSY are all 0.
  - Internal score/threshold registers are cleared.
  - IN_READY is 0 while RESET is high, and 1 on the first cycle after release.
- States: IDLE, SCAN, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY, capture SCORES and MARGIN_TH into registers.
  - Initialise best=score[0], bidx=0, second=most-negative (1 followed by zeros), idx=1. Go to SCAN.
- SCAN, one class per cycle:
  - If score[idx] > best (signed, strict): second<=best, best<=score[idx], bidx<=idx.
  - Else if score[idx] > second: second<=score[idx].
  - idx increments. After processing idx=N_CLASSES-1, load output registers and go to DONE.
- Tie rule: strict compare, so the lowest index wins among equal maxima. A tied score still becomes second, so the margin is 0.
- Margin: computed as best-second in DATA_W+1 bits, then saturated to the signed maximum (0x7FFF_FFFF for DATA_W=32). It is never negative.
- OUT_LOW_CONF = (margin < captured MARGIN_TH), unsigned compare.
- Latency: vector accepted at edge k; OUT_VALID is high after edge k+N_CLASSES-1 (7 edges for the default). No pipelining; throughput is one vector per N_CLASSES+1 cycles minimum.
- DONE:
  - OUT_VALID=1.
  - All OUT_* fields are held stable while OUT_READY=0, for any number of cycles.
  - IN_READY=0, so IN_VALID is ignored and nothing is captured.
  - On OUT_VALID&OUT_READY, go to IDLE; OUT_VALID drops the next cycle.
  - No same-cycle accept of a new vector.
- After handshake, the OUT_CLASS/SCORE/MARGIN/LOW_CONF registers keep the last result until the next DONE load.
- SCORES and MARGIN_TH changes after acceptance have no effect on the in-flight result.
- RESET asserted in SCAN or DONE aborts immediately: no OUT_VALID is produced, and all outputs return to their reset values.

Test Plan:
1. SCORES = {10,20,5,-3,100,7,99,0} (class0..7), MARGIN_TH=5, OUT_READY=1 -> OUT_CLASS=4, OUT_SCORE=100, OUT_MARGIN=1, OUT_LOW_CONF=1. OUT_VALID rises exactly 7 edges after the accept edge.
2. All scores 42:
   - MARGIN_TH=1 -> OUT_CLASS=0, OUT_MARGIN=0, OUT_LOW_CONF=1.
   - Repeat with MARGIN_TH=0 -> OUT_LOW_CONF=0.
3. score0=0x7FFF_FFFF, others 0x8000_0000, MARGIN_TH=0x100 -> OUT_CLASS=0, OUT_MARGIN=0x7FFF_FFFF (saturated), OUT_LOW_CONF=0. Also all-negative {-5,-1,-9,...,-9} -> OUT_CLASS=1, OUT_SCORE=-1, OUT_MARGIN=4.
4. Backpressure: hold OUT_READY=0 for 20 cycles in DONE while pulsing IN_VALID with new scores -> outputs unchanged, IN_READY=0, no capture. Raise OUT_READY for 1 cycle -> OUT_VALID=0 and IN_READY=1 the next cycle.
5. Snapshot: after accept, change SCORES to make class 7 largest and MARGIN_TH to 0 during SCAN -> result still matches the captured vector from test 1.
6. Assert RESET for 1 cycle at scan cycle 3 -> OUT_VALID never rises, all OUT_* = 0, BUSY=0. IN_READY=1 on the cycle after reset; a new vector then completes normally.
